// File: rtl/iir_pkg.sv
// Shared definitions for the stereo IIR AXI-Lite coefficient block.
// Register offsets, CTRL bit positions, coefficient type and helpers.
package iir_pkg;

    localparam int AXI_DW = 32;
    localparam int AXI_AW = 4;

    localparam logic [3:0] ADDR_CTRL = 4'h0;
    localparam logic [3:0] ADDR_A0   = 4'h4;
    localparam logic [3:0] ADDR_A1   = 4'h8;
    localparam logic [3:0] ADDR_B1   = 4'hC;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_CLR  = 1;
    localparam int CTRL_PEND = 2;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef logic signed [15:0] coef_t;

    typedef enum logic [1:0] {
        REG_CTRL = 2'd0,
        REG_A0   = 2'd1,
        REG_A1   = 2'd2,
        REG_B1   = 2'd3
    } reg_sel_e;

    typedef struct packed {
        logic [AXI_AW-1:0]   addr;
        logic [AXI_DW-1:0]   data;
        logic [AXI_DW/8-1:0] strb;
    } wr_req_t;

    function automatic reg_sel_e addr_to_sel(input logic [AXI_AW-1:0] a);
        return reg_sel_e'(a[3:2]);
    endfunction

    // Only the two low byte lanes carry coefficient bits.
    function automatic coef_t merge_coef(
        input coef_t             old,
        input logic [AXI_DW-1:0] d,
        input logic [3:0]        s
    );
        coef_t r;
        r = old;
        if (s[0]) r[7:0]  = d[7:0];
        if (s[1]) r[15:8] = d[15:8];
        return r;
    endfunction

endpackage

// File: rtl/axil_wr_join.sv
// AXI-Lite write-side join: holds AW and W independently, fires one
// register write when both are present and owns the B response.
module axil_wr_join
    import iir_pkg::*;
(
    input  logic              aclk,
    input  logic              areset,
    input  logic              live,
    input  logic [AXI_AW-1:0] s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [AXI_DW-1:0] s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    output logic              wr_stb,
    output wr_req_t           wr_req
);

    logic              aw_held;
    logic              w_held;
    logic              bvalid_q;
    logic [AXI_AW-1:0] awaddr_q;
    logic [AXI_DW-1:0] wdata_q;
    logic [3:0]        wstrb_q;

    logic aw_fire;
    logic w_fire;
    logic b_fire;

    assign s_axi_awready = live & ~aw_held & ~bvalid_q;
    assign s_axi_wready  = live & ~w_held & ~bvalid_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = RESP_OKAY;

    assign aw_fire = s_axi_awvalid & s_axi_awready;
    assign w_fire  = s_axi_wvalid & s_axi_wready;
    assign b_fire  = bvalid_q & s_axi_bready;

    // A channel arriving this cycle bypasses its empty holder.
    assign wr_stb = (aw_held | aw_fire) & (w_held | w_fire) & ~bvalid_q;

    always_comb begin
        wr_req      = '0;
        wr_req.addr = aw_held ? awaddr_q : s_axi_awaddr;
        wr_req.data = w_held ? wdata_q : s_axi_wdata;
        wr_req.strb = w_held ? wstrb_q : s_axi_wstrb;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            bvalid_q <= 1'b0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            if (b_fire) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end else begin
                if (aw_fire) begin
                    aw_held  <= 1'b1;
                    awaddr_q <= s_axi_awaddr;
                end
                if (w_fire) begin
                    w_held  <= 1'b1;
                    wdata_q <= s_axi_wdata;
                    wstrb_q <= s_axi_wstrb;
                end
            end
            if (wr_stb) begin
                bvalid_q <= 1'b1;
            end else if (b_fire) begin
                bvalid_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/iir_axil_coef_regs.sv
// AXI-Lite control/coefficient registers for the stereo 1st-order IIR.
// Staged coefficients move to the datapath only at sample boundaries.
module iir_axil_coef_regs
    import iir_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int COEF_WIDTH         = 16
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    input  logic                            sample_stb,
    output logic [COEF_WIDTH-1:0]           a0_o,
    output logic [COEF_WIDTH-1:0]           a1_o,
    output logic [COEF_WIDTH-1:0]           b1_o,
    output logic                            enable_o,
    output logic                            clear_o,
    output logic                            coef_upd_o
);

    logic    live;
    logic    wr_stb;
    wr_req_t wr_req;

    logic ctrl_en;
    logic ctrl_clr;
    logic pend;
    logic coef_upd_q;

    coef_t stg_a0;
    coef_t stg_a1;
    coef_t stg_b1;
    coef_t act_a0;
    coef_t act_a1;
    coef_t act_b1;

    logic                          rvalid_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] rd_word;
    logic                          ar_fire;
    reg_sel_e                      rd_sel;
    reg_sel_e                      wr_sel;
    logic                          coef_wr;
    logic                          commit;
    logic                          unused_bits;

    // Holds every ready low until the first cycle out of reset.
    always_ff @(posedge aclk) begin
        if (areset) live <= 1'b0;
        else        live <= 1'b1;
    end

    axil_wr_join u_wr_join (
        .aclk          (aclk),
        .areset        (areset),
        .live          (live),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .wr_stb        (wr_stb),
        .wr_req        (wr_req)
    );

    assign wr_sel  = addr_to_sel(wr_req.addr);
    assign coef_wr = wr_stb & (wr_sel != REG_CTRL);
    assign commit  = pend & (~ctrl_en | sample_stb);

    always_ff @(posedge aclk) begin
        if (areset) begin
            ctrl_en    <= 1'b0;
            ctrl_clr   <= 1'b0;
            pend       <= 1'b0;
            coef_upd_q <= 1'b0;
            stg_a0     <= '0;
            stg_a1     <= '0;
            stg_b1     <= '0;
            act_a0     <= '0;
            act_a1     <= '0;
            act_b1     <= '0;
        end else begin
            coef_upd_q <= commit;
            // Active copy takes pre-write staging on a colliding write.
            if (commit) begin
                act_a0 <= stg_a0;
                act_a1 <= stg_a1;
                act_b1 <= stg_b1;
            end
            if (coef_wr)     pend <= 1'b1;
            else if (commit) pend <= 1'b0;
            if (wr_stb) begin
                unique case (1'b1)
                    wr_sel == REG_CTRL: begin
                        if (wr_req.strb[0]) begin
                            ctrl_en  <= wr_req.data[CTRL_EN];
                            ctrl_clr <= wr_req.data[CTRL_CLR];
                        end
                    end
                    wr_sel == REG_A0:
                        stg_a0 <= merge_coef(stg_a0, wr_req.data, wr_req.strb);
                    wr_sel == REG_A1:
                        stg_a1 <= merge_coef(stg_a1, wr_req.data, wr_req.strb);
                    wr_sel == REG_B1:
                        stg_b1 <= merge_coef(stg_b1, wr_req.data, wr_req.strb);
                endcase
            end
        end
    end

    assign rd_sel  = addr_to_sel(s_axi_araddr);
    assign ar_fire = s_axi_arvalid & s_axi_arready;

    always_comb begin
        rd_word = '0;
        unique case (1'b1)
            rd_sel == REG_CTRL: begin
                rd_word[CTRL_EN]   = ctrl_en;
                rd_word[CTRL_CLR]  = ctrl_clr;
                rd_word[CTRL_PEND] = pend;
            end
            rd_sel == REG_A0: rd_word[15:0] = stg_a0;
            rd_sel == REG_A1: rd_word[15:0] = stg_a1;
            rd_sel == REG_B1: rd_word[15:0] = stg_b1;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else if (ar_fire) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_word;
        end else if (rvalid_q & s_axi_rready) begin
            rvalid_q <= 1'b0;
        end
    end

    assign s_axi_arready = live & ~rvalid_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = RESP_OKAY;

    assign a0_o       = act_a0;
    assign a1_o       = act_a1;
    assign b1_o       = act_b1;
    assign enable_o   = ctrl_en;
    assign clear_o    = ctrl_clr;
    assign coef_upd_o = coef_upd_q;

    assign unused_bits = ^{s_axi_araddr[1:0], wr_req.addr[1:0],
                           wr_req.data[31:16], wr_req.strb[3:2]};

endmodule
